// File: rtl/pc_control.sv
// Program-counter sequencer: IDLE/RUN/STEP/HALT control, stall handling and a saturating run-cycle counter.
// Optional alignment trap on advance is enabled by defining PC_ALIGN_CHECK_EN.
module pc_control #(
  parameter int unsigned        nbits    = 32,
  parameter logic [nbits-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [nbits-1:0] pc_next,
  input  logic             start,
  input  logic             step,
  input  logic             stall,
  input  logic             halt_instr,
  input  logic             clear,
  output logic [nbits-1:0] pc,
  output logic [nbits-1:0] pc_plus4,
  output logic             running,
  output logic             halted,
  output logic [31:0]      cycle_count,
  output logic             misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   active;
  logic   advance;
  logic   pc_load;
  logic   bad_target;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign active  = (state_q == RUN) || (state_q == STEP);
  assign advance = active && !stall && !halt_instr;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_set;
  logic misaligned_q;
  assign bad_target   = (pc_next[1:0] != 2'b00);
  assign misalign_set = advance && bad_target && !clear;
`else
  assign bad_target = 1'b0;
`endif

  // State, PC and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        pc          <= RESET_PC;
        cycle_count <= '0;
      end else begin
        if (pc_load) pc <= pc_next;
        if (active)  cycle_count <= sat_inc(cycle_count);
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky until clear or reset; the FSM is parked in HALT meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            misaligned_q <= 1'b0;
    else if (clear)        misaligned_q <= 1'b0;
    else if (misalign_set) misaligned_q <= 1'b1;
  end
`endif

  // Next-state and PC-load decision; halt_instr wins over stall
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start)     state_d = RUN;
          else if (step) state_d = STEP;
        end
        RUN: begin
          if (halt_instr) state_d = HALT;
          else if (advance) begin
            if (bad_target) state_d = HALT;
            else            pc_load = 1'b1;
          end
        end
        STEP: begin
          if (halt_instr) state_d = HALT;
          else if (advance) begin
            if (bad_target) begin
              state_d = HALT;
            end else begin
              pc_load = 1'b1;
              state_d = IDLE;
            end
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    pc_plus4 = pc + nbits'(4);
    running  = (state_q == RUN) || (state_q == STEP);
    halted   = (state_q == HALT);
`ifdef PC_ALIGN_CHECK_EN
    misaligned = misaligned_q;
`else
    misaligned = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: run/stall/step/halt/clear sequences and asynchronous reset.
module tb_pc_control;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] pc_next;
  logic          start, step, stall, halt_instr, clear;
  logic [NB-1:0] pc, pc_plus4;
  logic          running, halted, misaligned;
  logic [31:0]   cycle_count;

  logic          use_p4;
  logic [NB-1:0] pc_next_man;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb pc_next = use_p4 ? pc_plus4 : pc_next_man;

  pc_control #(.nbits(NB), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .start(start), .step(step),
    .stall(stall), .halt_instr(halt_instr), .clear(clear), .pc(pc),
    .pc_plus4(pc_plus4), .running(running), .halted(halted),
    .cycle_count(cycle_count), .misaligned(misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 0; step = 0; stall = 0; halt_instr = 0; clear = 0;
    use_p4 = 1'b1; pc_next_man = '0;
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_count", cycle_count, 0);
    check("rst_misaligned", misaligned, 0);

    // Continuous run with pc_next = pc_plus4
    rst_n = 1'b1; start = 1'b1;
    tick();
    check("run_enter_running", running, 1);
    check("run_enter_pc", pc, 0);
    start = 1'b0;
    tick();
    check("run_pc4", pc, 4);
    check("run_cnt1", cycle_count, 1);
    tick();
    check("run_pc8", pc, 8);
    check("run_cnt2", cycle_count, 2);
    check("pc_plus4_12", pc_plus4, 12);

    // Stall for two cycles at pc=8
    stall = 1'b1;
    tick();
    check("stall1_pc", pc, 8);
    tick();
    check("stall2_pc", pc, 8);
    check("stall2_cnt", cycle_count, 4);
    check("stall_running", running, 1);
    stall = 1'b0;
    tick();
    check("unstall_pc", pc, 12);
    check("unstall_cnt", cycle_count, 5);

    for (int i = 0; i < 5; i++) tick();
    check("run_pc20", pc, 32'h20);
    check("run_cnt10", cycle_count, 10);

    // Halt wins over stall; start/step ignored in HALT
    halt_instr = 1'b1; stall = 1'b1;
    tick();
    check("halt_halted", halted, 1);
    check("halt_running", running, 0);
    check("halt_pc", pc, 32'h20);
    check("halt_cnt", cycle_count, 11);
    halt_instr = 1'b0; stall = 1'b0; start = 1'b1; step = 1'b1;
    tick();
    check("halt_hold_halted", halted, 1);
    check("halt_hold_pc", pc, 32'h20);
    check("halt_hold_cnt", cycle_count, 11);
    step = 1'b0; clear = 1'b1;
    tick();
    check("clear_halted", halted, 0);
    check("clear_running", running, 0);
    check("clear_pc", pc, 0);
    check("clear_cnt", cycle_count, 0);
    clear = 1'b0; start = 1'b0;

    // Single step to 0x40
    use_p4 = 1'b0; pc_next_man = 32'h40; step = 1'b1;
    tick();
    check("step_enter_running", running, 1);
    check("step_enter_pc", pc, 0);
    step = 1'b0;
    tick();
    check("step_pc40", pc, 32'h40);
    check("step_done_running", running, 0);
    check("step_cnt", cycle_count, 1);
    tick();
    check("idle_hold_pc", pc, 32'h40);
    check("idle_hold_cnt", cycle_count, 1);

    // Step held off by a three-cycle stall
    step = 1'b1; stall = 1'b1; pc_next_man = 32'h44;
    tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step_stall_pc", pc, 32'h40);
      check("step_stall_running", running, 1);
    end
    check("step_stall_cnt", cycle_count, 4);
    stall = 1'b0;
    tick();
    check("step_release_pc", pc, 32'h44);
    check("step_release_running", running, 0);
    check("step_release_cnt", cycle_count, 5);

    // start takes priority over step: remain running after the load
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    tick();
    check("prio_running", running, 1);
    check("prio_cnt", cycle_count, 6);

    // Misaligned target
    pc_next_man = 32'h22;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", pc, 32'h44);
    check("align_misaligned", misaligned, 1);
    check("align_halted", halted, 1);
`else
    check("align_pc", pc, 32'h22);
    check("align_misaligned", misaligned, 0);
    check("align_running", running, 1);
`endif
    clear = 1'b1;
    tick();
    check("clear2_pc", pc, 0);
    check("clear2_misaligned", misaligned, 0);
    check("clear2_cnt", cycle_count, 0);
    clear = 1'b0;

    // Asynchronous reset mid-run at pc=0x10
    use_p4 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_areset_pc", pc, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("areset_pc", pc, 0);
    check("areset_running", running, 0);
    check("areset_cnt", cycle_count, 0);
    start = 1'b1;
    tick();
    check("rst_held_running", running, 0);
    start = 1'b0; rst_n = 1'b1;
    tick();
    check("post_rst_idle", running, 0);
    check("post_rst_pc", pc, 0);
    start = 1'b1;
    tick();
    check("post_rst_start", running, 1);
    start = 1'b0;

    // halt_instr during STEP
    clear = 1'b1;
    tick();
    clear = 1'b0; step = 1'b1;
    tick();
    step = 1'b0; halt_instr = 1'b1;
    tick();
    check("step_halt_halted", halted, 1);
    check("step_halt_pc", pc, 0);
    halt_instr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter nbits, default 32: width of program counter and next-PC input.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset and on clear.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pc_next  input  nbits  next PC, driven by the next-PC 2:1 mux output.
REQ-006 start  input  1  request continuous execution.
REQ-007 step  input  1  request one PC advance.
REQ-008 stall  input  1  hazard stall; blocks any PC update.
REQ-009 halt_instr  input  1  HALT instruction decoded at current PC.
REQ-010 clear  input  1  synchronous return to IDLE with PC and counter reinitialised.
REQ-011 pc  output  nbits  registered program counter.
REQ-012 pc_plus4  output  nbits  pc + 4 modulo 2^nbits, combinational; feeds the next-PC mux.
REQ-013 running  output  1  high in RUN or STEP.
REQ-014 halted  output  1  high in HALT.
REQ-015 cycle_count  output  32  cycles spent in RUN or STEP.
REQ-016 misaligned  output  1  alignment error flag (see Configuration).

Function
REQ-017 FSM states IDLE, RUN, STEP, HALT; pc updates only in RUN or STEP when stall=0 and halt_instr=0 (the "advance" condition).
REQ-018 IDLE: start=1 -> RUN; else step=1 -> STEP; start takes priority over step; pc holds.
REQ-019 RUN: on advance, pc <= pc_next next edge; halt_instr=1 -> HALT with pc unchanged, regardless of stall.
REQ-020 STEP: on advance, pc <= pc_next and state -> IDLE in the same edge; while stall=1, remain in STEP with pc held; halt_instr=1 -> HALT with pc unchanged.
REQ-021 HALT: pc held; start and step ignored; exit only via clear or reset.
REQ-022 clear=1 in any state: next edge state=IDLE, pc=RESET_PC, cycle_count=0, misaligned=0; clear overrides all other inputs.
REQ-023 cycle_count increments by 1 each edge where state is RUN or STEP (stalled cycles included); saturates at 32'hFFFF_FFFF.
REQ-024 pc_plus4 wraps: pc = all-ones-minus-3 gives pc_plus4 = 0.
REQ-025 running and halted are decoded from the state register, never both high.

Reset
REQ-026 rst_n=0 immediately forces state=IDLE, pc=RESET_PC, cycle_count=0, misaligned=0, independent of clk.
REQ-027 Reset asserted mid-RUN or mid-STEP aborts the pending update; after release, the block waits in IDLE for start or step.
REQ-028 First state change occurs on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN defined: an advance with pc_next[1:0] != 0 does not load pc, sets misaligned=1 and enters HALT on that edge.
REQ-030 PC_ALIGN_CHECK_EN undefined: pc_next is loaded as-is on every advance, and misaligned is tied to 0.

Verification
REQ-031 Reset, then start=1 for 1 cycle with pc_next=pc_plus4 -> pc sequence 0,4,8,12 on successive edges; running=1; cycle_count=3 after three RUN edges.
REQ-032 In RUN at pc=8, stall=1 for 2 cycles -> pc stays 8 for both cycles; cycle_count increases by 2; pc=12 on the edge after stall drops.
REQ-033 IDLE, step pulse with pc_next=0x40 -> pc=0x40 one edge later, state IDLE, running=0; a second step with stall=1 held 3 cycles -> pc unchanged until stall drops.
REQ-034 RUN at pc=0x20, halt_instr=1 -> halted=1, pc=0x20; start/step ignored; clear=1 -> pc=RESET_PC, cycle_count=0, IDLE.
REQ-035 rst_n low asynchronously mid-RUN at pc=0x10 -> pc=0 and running=0 before the next clk edge.
REQ-036 With PC_ALIGN_CHECK_EN, RUN with pc_next=0x22 -> pc held, misaligned=1, halted=1; without the macro -> pc=0x22, misaligned=0.
